// File: rtl/matriz_pkg.sv
// matriz_pkg: mode codes, shared FSM state encoding and width helper for the matrix op units
package matriz_pkg;
  localparam logic [1:0] MODE_TRANSPOSE = 2'b00;
  localparam logic [1:0] MODE_COPY = 2'b01;
  localparam logic [1:0] MODE_ANTI = 2'b10;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/matriz_row_gather.sv
// matriz_row_gather: picks the N source elements that form result row `row` for the selected mode
module matriz_row_gather
  import matriz_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8,
  parameter int RW = clog2(N)
) (
  input  logic [N*N*W-1:0] mat,
  input  logic [1:0]       mode,
  input  logic [RW-1:0]    row,
  output logic [N*W-1:0]   row_data
);
  int src;
  // reserved mode 11 falls through to the copy mapping
  always_comb begin
    row_data = '0;
    src = 0;
    for (int c = 0; c < N; c++) begin
      src = mode == MODE_TRANSPOSE ? N * c + int'(row) :
            mode == MODE_ANTI ? N * (N - 1 - c) + (N - 1 - int'(row)) :
            N * int'(row) + c;
      row_data[W*c +: W] = mat[W*src +: W];
    end
  end
endmodule

// File: rtl/matriz_transposta_seq.sv
// matriz_transposta_seq: latches an NxN matrix on start and writes one result row per clock
module matriz_transposta_seq
  import matriz_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [N*N*W-1:0] matrizA,
  output logic [N*N*W-1:0] matriz_resultante,
  output logic             busy,
  output logic             done
);
  localparam int RW = clog2(N);
  state_t state, nxt;
  logic [N*N*W-1:0] a_q;
  logic [1:0] mode_q;
  logic [RW-1:0] row_q;
  logic [N*W-1:0] row_data;
  logic last;
  matriz_row_gather #(.N(N), .W(W), .RW(RW)) u_gather (
    .mat(a_q),
    .mode(mode_q),
    .row(row_q),
    .row_data(row_data)
  );
  assign last = row_q == RW'(N - 1);
  assign busy = state == ST_RUN;
  assign done = state == ST_FIN;
  always_comb
    nxt = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
          state == ST_RUN ? (last ? ST_FIN : ST_RUN) : ST_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  // only the latched copy feeds the gather, so matrizA/mode are free to change mid-run
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      mode_q <= '0;
      row_q <= '0;
      matriz_resultante <= '0;
    end else if (state == ST_IDLE && start) begin
      a_q <= matrizA;
      mode_q <= mode;
      row_q <= '0;
      matriz_resultante <= '0;
    end else if (state == ST_RUN) begin
      matriz_resultante[N*W*row_q +: N*W] <= row_data;
      row_q <= last ? '0 : row_q + 1'b1;
    end
endmodule
